battle_game_ctrl: RTL and testbench

//  Parametrised top-level game controller for the battleship board game.

---
 rtl/battle_game_ctrl.sv | 127 ++++++++++++
 tb/tb_battle_game_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/battle_game_ctrl.sv
// battle_game_ctrl: battleship game sequencer owning ship counters and the optional turn timer.
// Define TURN_TIMER_EN to build the per-turn timer; otherwise turn_timeout is tied 0.
module battle_game_ctrl #(
  parameter int MAX_SHIPS   = 5,
  parameter int CNT_W       = 3,
  parameter int TURN_CYCLES = 750_000_000,
  parameter int TIMER_W     = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] ship_sel,
  input  logic             sel_confirm,
  input  logic             place_confirm,
  input  logic             pc_setup_done,
  input  logic             player_fire,
  input  logic             shot_done,
  input  logic             shot_sunk,
  input  logic             restart,
  output logic [2:0]       state_o,
  output logic             decision,
  output logic             colocation_ships,
  output logic             setup,
  output logic             player_turn,
  output logic             pc_turn,
  output logic             is_victory,
  output logic             is_defeat,
  output logic [CNT_W-1:0] ships_to_place,
  output logic [CNT_W-1:0] player_ships_left,
  output logic [CNT_W-1:0] pc_ships_left,
  output logic             turn_timeout
);
  localparam logic [2:0] S_DECISION    = 3'd0;
  localparam logic [2:0] S_COLOCATION  = 3'd1;
  localparam logic [2:0] S_SETUP       = 3'd2;
  localparam logic [2:0] S_PLAYER_TURN = 3'd3;
  localparam logic [2:0] S_PLAYER_WAIT = 3'd4;
  localparam logic [2:0] S_PC_TURN     = 3'd5;
  localparam logic [2:0] S_VICTORY     = 3'd6;
  localparam logic [2:0] S_DEFEAT      = 3'd7;
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_SHIPS);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] place_q, place_d, pl_q, pl_d, pc_q, pc_d;
  logic             timeout_q, timeout_d;
  logic             expire;
  logic [CNT_W-1:0] n_sel;

`ifdef TURN_TIMER_EN
  logic [TIMER_W-1:0] timer_q, timer_d;
  // Held at zero outside PLAYER_TURN, so every entry starts a fresh turn.
  always_comb timer_d = (state_q == S_PLAYER_TURN) ? timer_q + 1'b1 : '0;
  assign expire = (state_q == S_PLAYER_TURN) && (timer_q == TIMER_W'(TURN_CYCLES - 1)) && !player_fire;
  always_ff @(posedge clk or negedge rst)
    if (!rst) timer_q <= '0;
    else      timer_q <= timer_d;
`else
  assign expire = 1'b0;
`endif

  assign n_sel = (ship_sel == '0) ? ONE : (ship_sel > MAX_N) ? MAX_N : ship_sel;

  always_comb begin
    state_d   = state_q;
    place_d   = place_q;
    pl_d      = pl_q;
    pc_d      = pc_q;
    timeout_d = expire;
    case (state_q)
      S_DECISION: if (sel_confirm) begin
        state_d = S_COLOCATION;
        place_d = n_sel;
        pl_d    = n_sel;
        pc_d    = n_sel;
      end
      S_COLOCATION: if (place_confirm) begin
        place_d = (place_q != '0) ? place_q - 1'b1 : '0;
        state_d = (place_q <= ONE) ? S_SETUP : S_COLOCATION;
      end
      S_SETUP:       state_d = pc_setup_done ? S_PLAYER_TURN : S_SETUP;
      S_PLAYER_TURN: state_d = player_fire ? S_PLAYER_WAIT : expire ? S_PC_TURN : S_PLAYER_TURN;
      S_PLAYER_WAIT: if (shot_done) begin
        state_d = (shot_sunk && pc_q == ONE) ? S_VICTORY : S_PC_TURN;
        pc_d    = (shot_sunk && pc_q != '0) ? pc_q - 1'b1 : pc_q;
      end
      S_PC_TURN: if (shot_done) begin
        state_d = (shot_sunk && pl_q == ONE) ? S_DEFEAT : S_PLAYER_TURN;
        pl_d    = (shot_sunk && pl_q != '0) ? pl_q - 1'b1 : pl_q;
      end
      S_VICTORY, S_DEFEAT: if (restart) begin
        state_d = S_DECISION;
        place_d = '0;
        pl_d    = '0;
        pc_d    = '0;
      end
      default: state_d = S_DECISION;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= S_DECISION;
      place_q   <= '0;
      pl_q      <= '0;
      pc_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      place_q   <= place_d;
      pl_q      <= pl_d;
      pc_q      <= pc_d;
      timeout_q <= timeout_d;
    end

  assign state_o           = state_q;
  assign decision          = state_q == S_DECISION;
  assign colocation_ships  = state_q == S_COLOCATION;
  assign setup             = state_q == S_SETUP;
  assign player_turn       = state_q == S_PLAYER_TURN || state_q == S_PLAYER_WAIT;
  assign pc_turn           = state_q == S_PC_TURN;
  assign is_victory        = state_q == S_VICTORY;
  assign is_defeat         = state_q == S_DEFEAT;
  assign ships_to_place    = place_q;
  assign player_ships_left = pl_q;
  assign pc_ships_left     = pc_q;
  assign turn_timeout      = timeout_q;
endmodule

// File: tb/tb_battle_game_ctrl.sv
// tb_battle_game_ctrl: directed scenarios plus randomized play checked against a game-rules model.
module tb_battle_game_ctrl;
  localparam int MAXS = 5;
  localparam int TC   = 16;
`ifdef TURN_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic [2:0] ship_sel = '0;
  logic sel_confirm = 0, place_confirm = 0, pc_setup_done = 0, player_fire = 0;
  logic shot_done = 0, shot_sunk = 0, restart = 0;
  logic [2:0] state_o, ships_to_place, player_ships_left, pc_ships_left;
  logic decision, colocation_ships, setup, player_turn, pc_turn, is_victory, is_defeat, turn_timeout;

  int npass = 0, ntot = 0;
  int m_st = 0, m_place = 0, m_pl = 0, m_pc = 0, m_turn = 0;
  bit m_to = 0;

  battle_game_ctrl #(.MAX_SHIPS(MAXS), .CNT_W(3), .TURN_CYCLES(TC), .TIMER_W(5)) dut (
    .clk(clk), .rst(rst), .ship_sel(ship_sel), .sel_confirm(sel_confirm),
    .place_confirm(place_confirm), .pc_setup_done(pc_setup_done), .player_fire(player_fire),
    .shot_done(shot_done), .shot_sunk(shot_sunk), .restart(restart), .state_o(state_o),
    .decision(decision), .colocation_ships(colocation_ships), .setup(setup),
    .player_turn(player_turn), .pc_turn(pc_turn), .is_victory(is_victory), .is_defeat(is_defeat),
    .ships_to_place(ships_to_place), .player_ships_left(player_ships_left),
    .pc_ships_left(pc_ships_left), .turn_timeout(turn_timeout)
  );

  always #5 clk = ~clk;

  wire [6:0] flags = {decision, colocation_ships, setup, player_turn, pc_turn, is_victory, is_defeat};

  function automatic logic [6:0] exp_flags(input int st);
    return st == 0 ? 7'b1000000 : st == 1 ? 7'b0100000 : st == 2 ? 7'b0010000 :
           (st == 3 || st == 4) ? 7'b0001000 : st == 5 ? 7'b0000100 :
           st == 6 ? 7'b0000010 : 7'b0000001;
  endfunction

  // Game rules applied to the inputs present at a rising edge.
  task automatic model_step();
    int n;
    m_to = 0;
    case (m_st)
      0: if (sel_confirm) begin
        n = ship_sel == 0 ? 1 : (ship_sel > MAXS ? MAXS : int'(ship_sel));
        m_place = n; m_pl = n; m_pc = n; m_st = 1;
      end
      1: if (place_confirm) begin
        if (m_place > 0) m_place--;
        if (m_place == 0) m_st = 2;
      end
      2: if (pc_setup_done) begin m_st = 3; m_turn = 0; end
      3: if (player_fire) m_st = 4;
         else if (TMR && m_turn == TC - 1) begin m_st = 5; m_to = 1; end
         else m_turn++;
      4: if (shot_done) begin
        m_st = (shot_sunk && m_pc == 1) ? 6 : 5;
        if (shot_sunk && m_pc > 0) m_pc--;
      end
      5: if (shot_done) begin
        m_st = (shot_sunk && m_pl == 1) ? 7 : 3;
        if (m_st == 3) m_turn = 0;
        if (shot_sunk && m_pl > 0) m_pl--;
      end
      default: if (restart) begin m_st = 0; m_place = 0; m_pl = 0; m_pc = 0; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic sc, pl, su, pf, sd, sk, rs);
    ship_sel = sel; sel_confirm = sc; place_confirm = pl; pc_setup_done = su;
    player_fire = pf; shot_done = sd; shot_sunk = sk; restart = rs;
    tick();
    sel_confirm = 0; place_confirm = 0; pc_setup_done = 0; player_fire = 0;
    shot_done = 0; shot_sunk = 0; restart = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_st = 0; m_place = 0; m_pl = 0; m_pc = 0; m_turn = 0; m_to = 0;
    #2 rst = 1'b1;
  endtask

  // DECISION -> PLAYER_TURN with n ships requested
  task automatic start_game(input logic [2:0] sel, input int places);
    do_reset();
    drive(sel, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < places; i++) drive(0, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    #1;
    ntot++; if (state_o !== 3'd0 || flags !== 7'b1000000) $display("FAIL reset_pwr: state=%0d flags=%b want 0 1000000", state_o, flags); else npass++;
    rst = 1'b1;
    start_game(3, 3);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    ntot++; if (state_o !== 3'd5) $display("FAIL reach_pc_turn: state=%0d want 5", state_o); else npass++;
    rst = 1'b0;
    #1;
    ntot++; if (state_o !== 3'd0 || flags !== 7'b1000000) $display("FAIL reset_mid: state=%0d flags=%b want 0 1000000", state_o, flags); else npass++;
    ntot++; if ({ships_to_place, player_ships_left, pc_ships_left, turn_timeout} !== 10'd0)
      $display("FAIL reset_counts: place=%0d pl=%0d pc=%0d to=%b want all 0", ships_to_place, player_ships_left, pc_ships_left, turn_timeout); else npass++;
    #1 rst = 1'b1;
  endtask

  task automatic test_select_place();
    do_reset();
    drive(3, 1, 0, 0, 0, 0, 0, 0);
    ntot++; if (state_o !== 3'd1 || ships_to_place !== 3'd3) $display("FAIL sel3: state=%0d place=%0d want 1 3", state_o, ships_to_place); else npass++;
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    ntot++; if (state_o !== 3'd1 || ships_to_place !== 3'd2) $display("FAIL place1: state=%0d place=%0d want 1 2", state_o, ships_to_place); else npass++;
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    ntot++; if (state_o !== 3'd2 || ships_to_place !== 3'd0 || flags !== 7'b0010000) $display("FAIL place3: state=%0d place=%0d want 2 0", state_o, ships_to_place); else npass++;
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    ntot++; if (state_o !== 3'd2 || ships_to_place !== 3'd0) $display("FAIL spur_place: state=%0d place=%0d want 2 0", state_o, ships_to_place); else npass++;
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    ntot++; if (state_o !== 3'd3 || flags !== 7'b0001000) $display("FAIL setup_done: state=%0d flags=%b want 3 0001000", state_o, flags); else npass++;
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    ntot++; if (state_o !== 3'd3 || pc_ships_left !== 3'd3) $display("FAIL spur_shot: state=%0d pc=%0d want 3 3", state_o, pc_ships_left); else npass++;
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    ntot++; if (state_o !== 3'd4 || !player_turn) $display("FAIL fire: state=%0d pt=%b want 4 1", state_o, player_turn); else npass++;
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    ntot++; if (state_o !== 3'd5 || player_ships_left !== 3'd3) $display("FAIL spur_fire: state=%0d pl=%0d want 5 3", state_o, player_ships_left); else npass++;
  endtask

  task automatic test_victory();
    start_game(2, 2);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    ntot++; if (state_o !== 3'd5 || pc_ships_left !== 3'd1) $display("FAIL vic_hit1: state=%0d pc=%0d want 5 1", state_o, pc_ships_left); else npass++;
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    ntot++; if (state_o !== 3'd3) $display("FAIL vic_pcmiss: state=%0d want 3", state_o); else npass++;
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    ntot++; if (state_o !== 3'd6 || pc_ships_left !== 3'd0 || flags !== 7'b0000010) $display("FAIL vic: state=%0d pc=%0d want 6 0", state_o, pc_ships_left); else npass++;
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    ntot++; if (state_o !== 3'd6 || pc_ships_left !== 3'd0) $display("FAIL vic_hold: state=%0d pc=%0d want 6 0", state_o, pc_ships_left); else npass++;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    ntot++; if (state_o !== 3'd0 || {ships_to_place, player_ships_left, pc_ships_left} !== 9'd0)
      $display("FAIL restart: state=%0d pl=%0d want 0 0", state_o, player_ships_left); else npass++;
  endtask

  task automatic test_defeat_clamp();
    do_reset();
    drive(7, 1, 0, 0, 0, 0, 0, 0);
    ntot++; if (ships_to_place !== 3'd5 || player_ships_left !== 3'd5 || pc_ships_left !== 3'd5) $display("FAIL clamp7: place=%0d want 5", ships_to_place); else npass++;
    start_game(0, 1);
    ntot++; if (state_o !== 3'd3 || player_ships_left !== 3'd1 || pc_ships_left !== 3'd1) $display("FAIL clamp0: state=%0d pl=%0d want 3 1", state_o, player_ships_left); else npass++;
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 1, 0);
    ntot++; if (state_o !== 3'd7 || player_ships_left !== 3'd0 || flags !== 7'b0000001) $display("FAIL defeat: state=%0d pl=%0d want 7 0", state_o, player_ships_left); else npass++;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    ntot++; if (state_o !== 3'd0) $display("FAIL restart_def: state=%0d want 0", state_o); else npass++;
  endtask

  task automatic test_timeout();
    start_game(2, 2);
    for (int i = 0; i < TC - 1; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    ntot++; if (state_o !== 3'd3 || turn_timeout !== 1'b0) $display("FAIL pre_timeout: state=%0d to=%b want 3 0", state_o, turn_timeout); else npass++;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    ntot++; if (state_o !== (TMR ? 3'd5 : 3'd3) || turn_timeout !== TMR) $display("FAIL timeout: state=%0d to=%b want %0d %b", state_o, turn_timeout, TMR ? 5 : 3, TMR); else npass++;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    ntot++; if (turn_timeout !== 1'b0) $display("FAIL timeout_len: to=%b want 0", turn_timeout); else npass++;
    start_game(2, 2);
    for (int i = 0; i < TC - 1; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    ntot++; if (state_o !== 3'd4 || turn_timeout !== 1'b0) $display("FAIL fire_vs_timeout: state=%0d to=%b want 4 0", state_o, turn_timeout); else npass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      drive(3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
            1'($urandom), $urandom_range(0, 7) == 0);
      ntot++; if (state_o !== 3'(m_st)) $display("FAIL rnd_state c=%0d: got %0d want %0d", c, state_o, m_st); else npass++;
      ntot++; if (flags !== exp_flags(m_st)) $display("FAIL rnd_flags c=%0d: got %b want %b", c, flags, exp_flags(m_st)); else npass++;
      ntot++; if (ships_to_place !== 3'(m_place) || player_ships_left !== 3'(m_pl) || pc_ships_left !== 3'(m_pc))
        $display("FAIL rnd_counts c=%0d: got %0d/%0d/%0d want %0d/%0d/%0d", c, ships_to_place, player_ships_left, pc_ships_left, m_place, m_pl, m_pc); else npass++;
      ntot++; if (turn_timeout !== m_to) $display("FAIL rnd_timeout c=%0d: got %b want %b", c, turn_timeout, m_to); else npass++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_select_place();
    test_victory();
    test_defeat_clamp();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
